// File: rtl/vga_sprite_pkg.sv
// rtl/vga_sprite_pkg.sv - shared types and register map for the sprite attribute table
package vga_sprite_pkg;

  localparam int SPRITE_W = 24;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  localparam logic [ADDR_W-1:0] ADDR_CTRL = 5'd20;
  localparam logic [ADDR_W-1:0] ADDR_FCNT = 5'd21;

  localparam int CTRL_COMMIT_BIT = 0;
  localparam int CTRL_IRQCLR_BIT = 1;

  typedef struct packed {
    logic       en;
    logic [3:0] rom_id;
    logic [8:0] y;
    logic [9:0] x;
  } sprite_attr_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } commit_state_e;

endpackage

// File: rtl/sprite_attr_table_if.sv
// rtl/sprite_attr_table_if.sv - Avalon-MM slave register bus bundle
interface sprite_attr_table_if;
  import vga_sprite_pkg::*;

  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, write, read, address, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, write, read, address, writedata,
    output readdata
  );

endinterface

// File: rtl/vblank_sync.sv
// rtl/vblank_sync.sv - multi-flop synchronizer with registered rising-edge pulse
module vblank_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   rise_q;
  logic                   rise_d;

  // The pulse is registered so it lands SYNC_STAGES+1 cycles after the input edge
  assign rise_d = sync_q[SYNC_STAGES-1] & ~last_q;

  // Shift the asynchronous level through the synchronizer and track its previous value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/sprite_attr_table.sv
// rtl/sprite_attr_table.sv - double-buffered sprite attribute table committed on vertical blank
module sprite_attr_table
  import vga_sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 20,
  parameter int ENTRY_W     = 24,
  parameter int OUT_W       = 512,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  sprite_attr_table_if.slave      avs,
  input  logic                    vblank,
  output logic [OUT_W-1:0]        gl_output,
  output logic                    irq
);

  sprite_attr_t      shadow_q [NUM_SPRITES];
  sprite_attr_t      active_q [NUM_SPRITES];
  commit_state_e     state_q, state_d;
  logic              irq_q, irq_d;
  logic [31:0]       fcnt_q;
  logic [DATA_W-1:0] readdata_q, rdata_d;
  logic              vb_rise;
  logic              wr_en, rd_en;
  logic              commit_wr, irqclr_wr;
  logic              copy_en;
  logic [7:0]        unused_wdata_hi;

  vblank_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_vblank_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (vblank),
    .rise     (vb_rise)
  );

  assign wr_en     = avs.chipselect & avs.write;
  assign rd_en     = avs.chipselect & avs.read;
  assign commit_wr = wr_en && (avs.address == ADDR_CTRL) && avs.writedata[CTRL_COMMIT_BIT];
  assign irqclr_wr = wr_en && (avs.address == ADDR_CTRL) && avs.writedata[CTRL_IRQCLR_BIT];
  assign unused_wdata_hi = avs.writedata[31:24];

  // Commit FSM next state; a commit write landing in the copy cycle re-arms for the next frame
  always_comb begin
    state_d = state_q;
    copy_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (commit_wr) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (vb_rise) begin
          copy_en = 1'b1;
          state_d = commit_wr ? ST_ARMED : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Interrupt set has priority over a software clear in the same cycle
  always_comb begin
    irq_d = irq_q;
    if (copy_en)        irq_d = 1'b1;
    else if (irqclr_wr) irq_d = 1'b0;
  end

  // Control state, interrupt and frame counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      if (vb_rise) fcnt_q <= fcnt_q + 32'd1;
    end
  end

  // Shadow and active banks; the copy samples shadow before any same-cycle write lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (wr_en && (avs.address == ADDR_W'(i))) shadow_q[i] <= sprite_attr_t'(avs.writedata[SPRITE_W-1:0]);
        if (copy_en) active_q[i] <= shadow_q[i];
      end
    end
  end

  // Read mux; unmapped addresses return zero
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (avs.address == ADDR_W'(i)) rdata_d = {8'h00, shadow_q[i]};
    end
    if (avs.address == ADDR_CTRL) rdata_d = {29'h0, irq_q, (state_q == ST_ARMED), 1'b0};
    if (avs.address == ADDR_FCNT) rdata_d = fcnt_q;
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else if (rd_en) readdata_q <= rdata_d;
  end

  // Pack the active bank onto the display bus, unused upper bits zero
  always_comb begin
    gl_output = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      gl_output[i*ENTRY_W +: ENTRY_W] = active_q[i];
    end
  end

  assign avs.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_sprite_attr_table.sv
// tb/tb_sprite_attr_table.sv - directed self-checking bench for sprite_attr_table
module tb_sprite_attr_table;

  localparam int SYNC_STAGES = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         vblank;
  logic [511:0] gl_output;
  logic         irq;
  logic [31:0]  rd;
  int           n_cmp;
  int           n_err;

  sprite_attr_table_if bus ();

  sprite_attr_table #(
    .NUM_SPRITES (20),
    .ENTRY_W     (24),
    .OUT_W       (512),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .avs       (bus),
    .vblank    (vblank),
    .gl_output (gl_output),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic avs_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic avs_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = a;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    d = bus.readdata;
  endtask

  task automatic vblank_pulse();
    @(negedge clk);
    vblank = 1'b1;
    repeat (5) @(negedge clk);
    vblank = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset_n        = 1'b0;
    vblank         = 1'b0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;

    // 1. reset state
    repeat (3) @(negedge clk);
    check("rst_gl_output", gl_output, '0);
    check("rst_irq", irq, 1'b0);
    check("rst_readdata", bus.readdata, 32'h0);
    reset_n = 1'b1;
    avs_read(5'd21, rd);
    check("rst_fcnt", rd, 32'h0);

    // 2. shadow write/read, no commit means no output change
    avs_write(5'd3, 32'hFF80_3C14);
    avs_read(5'd3, rd);
    check("shadow3_read", rd, 32'h0080_3C14);
    repeat (3) vblank_pulse();
    check("no_commit_entry3", gl_output[95:72], 24'h0);
    avs_read(5'd21, rd);
    check("fcnt_after3", rd, 32'd3);

    // 3. commit with exact latency
    avs_write(5'd20, 32'h1);
    avs_read(5'd20, rd);
    check("ctrl_armed", rd, 32'h2);
    @(negedge clk);
    vblank = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    check("copy_not_early", gl_output[95:72], 24'h0);
    @(negedge clk);
    check("copy_entry3", gl_output[95:72], 24'h803C14);
    check("copy_irq", irq, 1'b1);
    vblank = 1'b0;
    repeat (4) @(negedge clk);
    avs_read(5'd20, rd);
    check("ctrl_after_copy", rd, 32'h4);
    avs_write(5'd20, 32'h2);
    check("irq_cleared", irq, 1'b0);

    // 4. shadow write in the copy cycle
    avs_write(5'd5, 32'h0081_2345);
    avs_write(5'd20, 32'h1);
    @(negedge clk);
    vblank = 1'b1;
    repeat (SYNC_STAGES + 1) @(negedge clk);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = 5'd5;
    bus.writedata  = 32'h008A_BCDE;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    check("race_entry5_old", gl_output[143:120], 24'h812345);
    check("race_entry3_kept", gl_output[95:72], 24'h803C14);
    vblank = 1'b0;
    repeat (4) @(negedge clk);
    avs_read(5'd5, rd);
    check("race_shadow5_new", rd, 32'h008A_BCDE);
    avs_write(5'd20, 32'h3);
    check("commit_clr_irq", irq, 1'b0);
    avs_read(5'd20, rd);
    check("ctrl_rearmed", rd, 32'h2);
    vblank_pulse();
    check("second_copy_entry5", gl_output[143:120], 24'h8ABCDE);
    check("second_copy_irq", irq, 1'b1);
    avs_read(5'd21, rd);
    check("fcnt_after6", rd, 32'd6);

    // 5. reset while armed discards the commit
    avs_write(5'd20, 32'h1);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst2_gl_output", gl_output, '0);
    reset_n = 1'b1;
    vblank_pulse();
    check("rst2_no_copy", gl_output, '0);
    check("rst2_irq", irq, 1'b0);
    avs_read(5'd20, rd);
    check("rst2_ctrl", rd, 32'h0);
    avs_read(5'd3, rd);
    check("rst2_shadow3", rd, 32'h0);
    avs_read(5'd21, rd);
    check("rst2_fcnt", rd, 32'd1);

    // 6. unmapped address and frame counter wrap
    avs_write(5'd3, 32'h0012_3456);
    avs_write(5'd25, 32'hFFFF_FFFF);
    avs_read(5'd25, rd);
    check("unmapped_read", rd, 32'h0);
    avs_read(5'd3, rd);
    check("unmapped_no_alias", rd, 32'h0012_3456);
    avs_read(5'd20, rd);
    check("unmapped_ctrl", rd, 32'h0);
    check("unmapped_gl", gl_output, '0);
    @(negedge clk);
    force dut.fcnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.fcnt_q;
    avs_read(5'd21, rd);
    check("fcnt_forced", rd, 32'hFFFF_FFFF);
    vblank_pulse();
    avs_read(5'd21, rd);
    check("fcnt_wrap", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
